pwr_toggle_accum: RTL and testbench
===================================

PWR_TOGGLE_ACCUM -- requirements
Module: pwr_toggle_accum

Interface
REQ-001 SHALL have parameter N_SIG, default 8, meaning the number of monitored cell-output nets (1..32).
REQ-002 SHALL have parameter CNT_W, default 16, meaning the width of each per-class toggle counter.
REQ-003 SHALL have port C, input, 1, the single clock; all state changes on posedge C.
REQ-004 SHALL have port R, input, 1, reset: asynchronous, active-high.
REQ-005 SHALL have port en, input, 1, meaning sampling is enabled this cycle.
REQ-006 SHALL have port sig, input, N_SIG, meaning the monitored cell outputs (BUF/NOT/NAND/NOR Y nets).
REQ-007 SHALL have port cls, input, 2*N_SIG, meaning a static 2-bit class per net: 0=BUF, 1=NOT, 2=NAND, 3=NOR.
REQ-008 SHALL have port rd_req, input, 1, meaning a snapshot request.
REQ-009 SHALL have port rd_ack, input, 1, meaning the consumer has taken the snapshot.
REQ-010 SHALL have port rd_valid, output, 1, meaning snapshot outputs are stable and valid.
REQ-011 SHALL have port cnt_out, output, 4*CNT_W, meaning the snapshot counters; class k occupies bits [k*CNT_W +: CNT_W].
REQ-012 SHALL have port ovf_out, output, 4, meaning per-class saturation flags of the snapshot epoch.
REQ-013 SHALL have port energy_out, output, CNT_W+4, meaning the weighted energy snapshot (present only with PWR_WEIGHT_EN).

Function
REQ-014 SHALL register sig into prev when en=1; toggle vector = sig ^ prev, evaluated only when en=1 and primed=1.
REQ-015 SHALL set primed on the first en=1 cycle after reset, without counting on that cycle.
REQ-016 SHALL add, per class, the population count of toggled nets in that class to the live counter on the same edge.
REQ-017 SHALL saturate each live counter at 2^CNT_W-1 and set its sticky ovf bit; no wrap-around.
REQ-018 SHALL implement FSM IDLE -> SNAP -> HOLD -> IDLE.
REQ-019 SHALL move IDLE->SNAP when rd_req=1; SNAP->HOLD unconditionally after one cycle; HOLD->IDLE when rd_ack=1.
REQ-020 SHALL, in SNAP, copy live counters and ovf into the output registers and clear the live counters to this cycle's toggle increments, so no toggle is lost or double counted.
REQ-021 SHALL drive rd_valid=1 only in HOLD; cnt_out/ovf_out/energy_out SHALL be stable while rd_valid=1.
REQ-022 SHALL ignore rd_req in SNAP/HOLD; live counting continues in all states.
REQ-023 SHALL treat rd_ack outside HOLD as a no-op.
REQ-024 SHALL give a read latency of 2 edges from rd_req sampled high to rd_valid high.

Reset
REQ-025 SHALL, on R=1, asynchronously clear prev, primed, live counters, ovf, all outputs (rd_valid=0, cnt_out=0, ovf_out=0, energy_out=0) and set FSM to IDLE.
REQ-026 SHALL, on R mid-HOLD, drop rd_valid immediately and discard the pending snapshot.

Configuration
REQ-027 SHALL, with PWR_WEIGHT_EN defined, accumulate energy += 1/2/4/4 per toggle of class BUF/NOT/NAND/NOR, saturating, snapshotted and cleared like the counters.
REQ-028 SHALL, without PWR_WEIGHT_EN, omit the energy accumulator and tie energy_out to 0.

Structure
REQ-029 SHALL place class encodings, FSM state typedef and weight constants in shared package pwr_pkg.
REQ-030 SHALL use one sub-module pwr_class_popcnt (per-class popcount of a toggle vector).

Verification
REQ-031 Reset then en=1 with sig toggling: first cycle -> all counters 0 (priming only).
REQ-032 N_SIG=8, cls all NAND, sig alternating 0x00/0xFF for 10 counted cycles, read -> NAND count=80, others 0.
REQ-033 Preload NOT counter to 0xFFFE, 3 NOT toggles -> count 0xFFFF, ovf_out[1]=1.
REQ-034 rd_req on a cycle with 2 BUF toggles -> snapshot excludes them, next snapshot BUF=2.
REQ-035 rd_req held during HOLD, rd_ack after 5 cycles -> one snapshot, outputs stable for all 5 cycles.
REQ-036 PWR_WEIGHT_EN, one toggle of each class, read -> energy_out=11; R asserted in HOLD -> rd_valid=0 same cycle.

Source files
------------

// File: rtl/pwr_pkg.sv
// pwr_pkg: shared definitions for the toggle-activity power accumulator.
//   - cls_e    : 2-bit cell class carried per monitored net (BUF/NOT/NAND/NOR)
//   - state_e  : snapshot handshake FSM states
//   - N_CLS    : number of cell classes (one live counter each)
//   - PC_W     : width of a per-class popcount (up to 32 nets -> 6 bits)
//   - W_*      : relative switching-energy weight of one toggle per class
//   - cls_weight() : maps a class code to its energy weight
package pwr_pkg;

   typedef enum logic [1:0] {
      CLS_BUF  = 2'd0,
      CLS_NOT  = 2'd1,
      CLS_NAND = 2'd2,
      CLS_NOR  = 2'd3
   } cls_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SNAP = 2'd1,
      ST_HOLD = 2'd2
   } state_e;

   localparam int N_CLS = 4;
   localparam int PC_W  = 6;

   localparam int W_BUF  = 1;
   localparam int W_NOT  = 2;
   localparam int W_NAND = 4;
   localparam int W_NOR  = 4;

   // Energy weight of a single toggle on a net of the given class.
   function automatic int cls_weight(input logic [1:0] c);
      int w;
      case (c)
         CLS_BUF:  w = W_BUF;
         CLS_NOT:  w = W_NOT;
         CLS_NAND: w = W_NAND;
         default:  w = W_NOR;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/pwr_class_popcnt.sv
// pwr_class_popcnt: counts how many toggled nets fall into each cell class.
// Parameters:
//   N_SIG : number of monitored nets (1..32)
// Ports:
//   tog [N_SIG]      : toggle vector, one bit per net
//   cls [2*N_SIG]    : static 2-bit class per net (net i at [2*i +: 2])
//   pop [N_CLS*PC_W] : per-class toggle count, class k at [k*PC_W +: PC_W]
module pwr_class_popcnt
   import pwr_pkg::*;
#(
   parameter int N_SIG = 8
) (
   input  logic [N_SIG-1:0]      tog,
   input  logic [2*N_SIG-1:0]    cls,
   output logic [N_CLS*PC_W-1:0] pop
);

   // Each net contributes one to the bucket of its own class when it toggled.
   always_comb begin
      pop = '0;
      for (int k = 0; k < N_CLS; k++) begin
         for (int i = 0; i < N_SIG; i++) begin
            if (tog[i] && (cls[2*i +: 2] == 2'(k))) begin
               pop[k*PC_W +: PC_W] = pop[k*PC_W +: PC_W] + PC_W'(1);
            end
         end
      end
   end

endmodule

// File: rtl/pwr_toggle_accum.sv
// pwr_toggle_accum: per-class toggle counters for cell-output nets with a
// snapshot/acknowledge read port.
// Optional feature macro: PWR_WEIGHT_EN (weighted energy accumulator; when
// undefined, energy_out is tied to zero).
// Parameters:
//   N_SIG : number of monitored nets (1..32)
//   CNT_W : width of each per-class counter
// Ports:
//   C          : clock, all state changes on its rising edge
//   R          : asynchronous active-high reset
//   en         : sample sig this cycle
//   sig        : monitored net values
//   cls        : static 2-bit class per net
//   rd_req     : snapshot request (honoured only in IDLE)
//   rd_ack     : consumer has taken the snapshot (honoured only in HOLD)
//   rd_valid   : snapshot outputs valid and stable
//   cnt_out    : snapshot counters, class k at [k*CNT_W +: CNT_W]
//   ovf_out    : per-class saturation flags of the snapshot epoch
//   energy_out : weighted energy snapshot
module pwr_toggle_accum
   import pwr_pkg::*;
#(
   parameter int N_SIG = 8,
   parameter int CNT_W = 16
) (
   input  logic                   C,
   input  logic                   R,
   input  logic                   en,
   input  logic [N_SIG-1:0]       sig,
   input  logic [2*N_SIG-1:0]     cls,
   input  logic                   rd_req,
   input  logic                   rd_ack,
   output logic                   rd_valid,
   output logic [N_CLS*CNT_W-1:0] cnt_out,
   output logic [N_CLS-1:0]       ovf_out,
   output logic [CNT_W+3:0]       energy_out
);

   localparam int SUM_W = CNT_W + PC_W;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [N_SIG-1:0]       prev_q, prev_d;
   logic                   primed_q, primed_d;
   logic [N_SIG-1:0]       tog;
   logic [N_CLS*PC_W-1:0]  pop;
   logic [CNT_W-1:0]       cnt_q [N_CLS];
   logic [CNT_W-1:0]       cnt_d [N_CLS];
   logic [CNT_W-1:0]       base  [N_CLS];
   logic [SUM_W-1:0]       sum   [N_CLS];
   logic [N_CLS-1:0]       ovf_q, ovf_d;
   state_e                 state_q, state_d;
   logic                   rd_valid_q, rd_valid_d;
   logic [N_CLS*CNT_W-1:0] cnt_out_q, cnt_out_d;
   logic [N_CLS-1:0]       ovf_out_q, ovf_out_d;
   logic                   snap;

   assign snap = (state_q == ST_SNAP);

   // The first enabled sample only primes prev; toggles are counted from the
   // second enabled sample onward so a power-up value is never a "toggle".
   always_comb begin
      tog      = (en && primed_q) ? (sig ^ prev_q) : '0;
      prev_d   = en ? sig : prev_q;
      primed_d = primed_q | en;
   end

   pwr_class_popcnt #(
      .N_SIG (N_SIG)
   ) u_popcnt (
      .tog (tog),
      .cls (cls),
      .pop (pop)
   );

   // Saturating live counters. During SNAP the old value is handed to the
   // output registers, so the new epoch starts from this cycle's increment
   // alone and every toggle lands in exactly one snapshot.
   always_comb begin
      ovf_d = '0;
      for (int k = 0; k < N_CLS; k++) begin
         base[k] = snap ? '0 : cnt_q[k];
         sum[k]  = SUM_W'(base[k]) + SUM_W'(pop[k*PC_W +: PC_W]);
         if (sum[k] > SUM_W'(CNT_MAX)) begin
            cnt_d[k] = CNT_MAX;
            ovf_d[k] = 1'b1;
         end else begin
            cnt_d[k] = sum[k][CNT_W-1:0];
            ovf_d[k] = snap ? 1'b0 : ovf_q[k];
         end
      end
   end

   // Snapshot handshake: IDLE waits for a request, SNAP captures for one
   // cycle, HOLD keeps outputs frozen until the consumer acknowledges.
   always_comb begin
      state_d    = state_q;
      rd_valid_d = rd_valid_q;
      cnt_out_d  = cnt_out_q;
      ovf_out_d  = ovf_out_q;
      case (state_q)
         ST_IDLE: begin
            if (rd_req) begin
               state_d = ST_SNAP;
            end
         end
         ST_SNAP: begin
            state_d    = ST_HOLD;
            rd_valid_d = 1'b1;
            ovf_out_d  = ovf_q;
            for (int k = 0; k < N_CLS; k++) begin
               cnt_out_d[k*CNT_W +: CNT_W] = cnt_q[k];
            end
         end
         ST_HOLD: begin
            if (rd_ack) begin
               state_d    = ST_IDLE;
               rd_valid_d = 1'b0;
            end
         end
         default: begin
            state_d    = ST_IDLE;
            rd_valid_d = 1'b0;
         end
      endcase
   end

   // All counting and handshake state; reset discards any pending snapshot.
   always_ff @(posedge C or posedge R) begin
      if (R) begin
         prev_q     <= '0;
         primed_q   <= 1'b0;
         ovf_q      <= '0;
         state_q    <= ST_IDLE;
         rd_valid_q <= 1'b0;
         cnt_out_q  <= '0;
         ovf_out_q  <= '0;
         for (int k = 0; k < N_CLS; k++) begin
            cnt_q[k] <= '0;
         end
      end else begin
         prev_q     <= prev_d;
         primed_q   <= primed_d;
         ovf_q      <= ovf_d;
         state_q    <= state_d;
         rd_valid_q <= rd_valid_d;
         cnt_out_q  <= cnt_out_d;
         ovf_out_q  <= ovf_out_d;
         for (int k = 0; k < N_CLS; k++) begin
            cnt_q[k] <= cnt_d[k];
         end
      end
   end

   assign rd_valid = rd_valid_q;
   assign cnt_out  = cnt_out_q;
   assign ovf_out  = ovf_out_q;

`ifdef PWR_WEIGHT_EN
   localparam int EN_W    = CNT_W + 4;
   localparam int E_INC_W = PC_W + 3;
   localparam int E_SUM_W = EN_W + E_INC_W;
   localparam logic [EN_W-1:0] EN_MAX = '1;

   logic [EN_W-1:0]    energy_q, energy_d;
   logic [EN_W-1:0]    energy_out_q, energy_out_d;
   logic [EN_W-1:0]    e_base;
   logic [E_INC_W-1:0] e_inc;
   logic [E_SUM_W-1:0] e_sum;

   // Weighted energy follows the same saturate/snapshot/restart rules as the
   // per-class counters.
   always_comb begin
      e_inc = '0;
      for (int k = 0; k < N_CLS; k++) begin
         e_inc = e_inc + E_INC_W'(cls_weight(2'(k))) * E_INC_W'(pop[k*PC_W +: PC_W]);
      end
      e_base       = snap ? '0 : energy_q;
      e_sum        = E_SUM_W'(e_base) + E_SUM_W'(e_inc);
      energy_d     = (e_sum > E_SUM_W'(EN_MAX)) ? EN_MAX : e_sum[EN_W-1:0];
      energy_out_d = snap ? energy_q : energy_out_q;
   end

   // Energy accumulator and its snapshot register.
   always_ff @(posedge C or posedge R) begin
      if (R) begin
         energy_q     <= '0;
         energy_out_q <= '0;
      end else begin
         energy_q     <= energy_d;
         energy_out_q <= energy_out_d;
      end
   end

   assign energy_out = energy_out_q;
`else
   assign energy_out = '0;
`endif

endmodule

// File: tb/tb_pwr_toggle_accum.sv
// tb_pwr_toggle_accum: randomized and directed bench for pwr_toggle_accum with
// a queue-based scoreboard. Honours PWR_WEIGHT_EN for the energy output.
module tb_pwr_toggle_accum;

`ifdef PWR_WEIGHT_EN
   localparam bit WEIGHT = 1'b1;
`else
   localparam bit WEIGHT = 1'b0;
`endif
   localparam int CMAX = 65535;
   localparam int EMAX = (1 << 20) - 1;

   logic        C = 1'b0;
   logic        R = 1'b1;
   logic        en = 1'b0;
   logic [7:0]  sig = '0;
   logic [15:0] cls = '0;
   logic        rd_req = 1'b0;
   logic        rd_ack = 1'b0;
   logic        rd_valid;
   logic [63:0] cnt_out;
   logic [3:0]  ovf_out;
   logic [19:0] energy_out;

   typedef struct {
      logic [63:0] cnt;
      logic [3:0]  ovf;
      logic [19:0] energy;
   } snap_t;

   snap_t sb_q[$];

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state: plain integer counters per class.
   int       live_m [4];
   bit [3:0] ovf_m;
   int       energy_m;
   bit [7:0] prev_m;
   bit       primed_m;
   int       stage_m;
   bit       exp_valid;

   logic [7:0]  cur_sig = '0;
   logic [15:0] cur_cls = '0;

   pwr_toggle_accum #(
      .N_SIG (8),
      .CNT_W (16)
   ) dut (
      .C          (C),
      .R          (R),
      .en         (en),
      .sig        (sig),
      .cls        (cls),
      .rd_req     (rd_req),
      .rd_ack     (rd_ack),
      .rd_valid   (rd_valid),
      .cnt_out    (cnt_out),
      .ovf_out    (ovf_out),
      .energy_out (energy_out)
   );

   always #5 C = ~C;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic modelReset();
      for (int k = 0; k < 4; k++) live_m[k] = 0;
      ovf_m     = '0;
      energy_m  = 0;
      prev_m    = '0;
      primed_m  = 1'b0;
      stage_m   = 0;
      exp_valid = 1'b0;
      sb_q.delete();
   endtask

   // Effect of one rising edge, derived from the counting/snapshot rules.
   task automatic modelStep(input bit e, input logic [7:0] s, input logic [15:0] c,
                            input bit rq, input bit ak);
      int    inc [4];
      int    e_inc;
      snap_t item;
      for (int k = 0; k < 4; k++) inc[k] = 0;
      if (e && primed_m) begin
         for (int i = 0; i < 8; i++) begin
            if (s[i] != prev_m[i]) inc[c[2*i +: 2]]++;
         end
      end
      if (stage_m == 1) begin
         item.cnt    = {live_m[3][15:0], live_m[2][15:0], live_m[1][15:0], live_m[0][15:0]};
         item.ovf    = ovf_m;
         item.energy = WEIGHT ? energy_m[19:0] : 20'd0;
         sb_q.push_back(item);
         for (int k = 0; k < 4; k++) live_m[k] = 0;
         ovf_m    = '0;
         energy_m = 0;
      end
      for (int k = 0; k < 4; k++) begin
         if (live_m[k] + inc[k] > CMAX) begin
            live_m[k] = CMAX;
            ovf_m[k]  = 1'b1;
         end else begin
            live_m[k] = live_m[k] + inc[k];
         end
      end
      e_inc    = inc[0] * 1 + inc[1] * 2 + inc[2] * 4 + inc[3] * 4;
      energy_m = (energy_m + e_inc > EMAX) ? EMAX : energy_m + e_inc;
      if (e) begin
         prev_m   = s;
         primed_m = 1'b1;
      end
      case (stage_m)
         0: if (rq) stage_m = 1;
         1: stage_m = 2;
         default: if (ak) stage_m = 0;
      endcase
      exp_valid = (stage_m == 2);
   endtask

   // One clock cycle of stimulus; called and returns on a falling edge.
   task automatic applyStimulus(input bit e, input logic [7:0] s, input logic [15:0] c,
                                input bit rq, input bit ak);
      en = e; sig = s; cls = c; rd_req = rq; rd_ack = ak;
      cur_sig = s; cur_cls = c;
      @(posedge C);
      #1 modelStep(e, s, c, rq, ak);
      @(negedge C);
   endtask

   // Asynchronous reset applied mid-cycle; outputs must clear immediately.
   task automatic applyReset();
      R = 1'b1;
      modelReset();
      #1;
      checkOutput("reset_rd_valid", 64'(rd_valid), 64'd0);
      checkOutput("reset_cnt_out", cnt_out, 64'd0);
      checkOutput("reset_ovf_out", 64'(ovf_out), 64'd0);
      checkOutput("reset_energy_out", 64'(energy_out), 64'd0);
      @(posedge C);
      @(negedge C);
      R = 1'b0;
      en = 1'b0; rd_req = 1'b0; rd_ack = 1'b0;
   endtask

   // Request, wait through SNAP, optionally check constants, hold, acknowledge.
   task automatic readSnapshot(input int hold_cycles, input bit do_chk, input logic [63:0] exp_cnt,
                               input logic [3:0] exp_ovf, input logic [19:0] exp_en);
      applyStimulus(1'b0, cur_sig, cur_cls, 1'b1, 1'b0);
      applyStimulus(1'b0, cur_sig, cur_cls, 1'b0, 1'b0);
      if (do_chk) begin
         checkOutput("latency_rd_valid", 64'(rd_valid), 64'd1);
         checkOutput("direct_cnt_out", cnt_out, exp_cnt);
         checkOutput("direct_ovf_out", 64'(ovf_out), 64'(exp_ovf));
         checkOutput("direct_energy_out", 64'(energy_out), 64'(exp_en));
      end
      for (int h = 0; h < hold_cycles; h++) begin
         applyStimulus(1'b0, cur_sig, cur_cls, 1'b1, 1'b0);
      end
      applyStimulus(1'b0, cur_sig, cur_cls, 1'b0, 1'b1);
   endtask

   // Monitor: pops an expected snapshot on each rising rd_valid and checks
   // that the outputs stay frozen for every cycle rd_valid remains high.
   initial begin
      bit    last_valid;
      snap_t cur;
      last_valid = 1'b0;
      cur.cnt = '0; cur.ovf = '0; cur.energy = '0;
      forever begin
         @(posedge C);
         #3;
         checkOutput("rd_valid", 64'(rd_valid), 64'(exp_valid));
         if (rd_valid && !last_valid) begin
            if (sb_q.size() == 0) begin
               checkOutput("snapshot_unexpected", 64'd1, 64'd0);
            end else begin
               cur = sb_q.pop_front();
               checkOutput("snap_cnt_out", cnt_out, cur.cnt);
               checkOutput("snap_ovf_out", 64'(ovf_out), 64'(cur.ovf));
               checkOutput("snap_energy_out", 64'(energy_out), 64'(cur.energy));
            end
         end else if (rd_valid && last_valid) begin
            checkOutput("hold_cnt_out", cnt_out, cur.cnt);
            checkOutput("hold_ovf_out", 64'(ovf_out), 64'(cur.ovf));
            checkOutput("hold_energy_out", 64'(energy_out), 64'(cur.energy));
         end
         last_valid = rd_valid;
      end
   end

   initial begin
      logic [7:0]  s;
      logic [15:0] c;
      modelReset();
      @(negedge C);
      applyReset();

      // Priming cycle only: nothing counted.
      applyStimulus(1'b1, 8'h55, 16'hAAAA, 1'b0, 1'b0);
      readSnapshot(0, 1'b1, 64'd0, 4'd0, 20'd0);

      // All NAND, 10 counted cycles of 8 toggles each.
      for (int i = 0; i < 10; i++) begin
         s = (i % 2 == 0) ? 8'hAA : 8'h55;
         applyStimulus(1'b1, s, 16'hAAAA, 1'b0, 1'b0);
      end
      readSnapshot(0, 1'b1, {16'd0, 16'd80, 16'd0, 16'd0}, 4'd0, WEIGHT ? 20'd320 : 20'd0);

      // Toggles in the capture cycle go to the next epoch.
      applyStimulus(1'b1, 8'h54, 16'h0000, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'h54, 16'h0000, 1'b1, 1'b0);
      applyStimulus(1'b1, 8'h57, 16'h0000, 1'b0, 1'b0);
      checkOutput("split_first_cnt", cnt_out, {16'd0, 16'd0, 16'd0, 16'd1});
      applyStimulus(1'b0, 8'h57, 16'h0000, 1'b0, 1'b1);
      readSnapshot(0, 1'b1, {16'd0, 16'd0, 16'd0, 16'd2}, 4'd0, WEIGHT ? 20'd2 : 20'd0);

      // Request held through a long HOLD: one snapshot, stable outputs.
      readSnapshot(5, 1'b1, 64'd0, 4'd0, 20'd0);
      applyStimulus(1'b0, cur_sig, cur_cls, 1'b0, 1'b0);
      applyStimulus(1'b0, cur_sig, cur_cls, 1'b0, 1'b1);

      // Saturation of the NOT counter: 0xFFFE then 3 more toggles.
      applyReset();
      s = 8'h00;
      applyStimulus(1'b1, s, 16'h5555, 1'b0, 1'b0);
      for (int i = 0; i < 8191; i++) begin
         s = s ^ 8'hFF;
         applyStimulus(1'b1, s, 16'h5555, 1'b0, 1'b0);
      end
      s = s ^ 8'h3F;
      applyStimulus(1'b1, s, 16'h5555, 1'b0, 1'b0);
      s = s ^ 8'h07;
      applyStimulus(1'b1, s, 16'h5555, 1'b0, 1'b0);
      readSnapshot(0, 1'b1, {16'd0, 16'd0, 16'hFFFF, 16'd0}, 4'b0010, WEIGHT ? 20'h20002 : 20'd0);

      // One toggle per class, then reset while HOLD.
      applyReset();
      applyStimulus(1'b1, 8'h00, 16'h00E4, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'h0F, 16'h00E4, 1'b0, 1'b0);
      applyStimulus(1'b0, 8'h0F, 16'h00E4, 1'b1, 1'b0);
      applyStimulus(1'b0, 8'h0F, 16'h00E4, 1'b0, 1'b0);
      checkOutput("class_mix_cnt", cnt_out, {16'd1, 16'd1, 16'd1, 16'd1});
      checkOutput("class_mix_energy", 64'(energy_out), WEIGHT ? 64'd11 : 64'd0);
      applyReset();

      // Randomized traffic against the reference model.
      c = 16'($urandom);
      for (int i = 0; i < 600; i++) begin
         if (i % 64 == 0) c = 16'($urandom);
         applyStimulus(($urandom % 4) != 0, 8'($urandom), c,
                       ($urandom % 6) == 0, ($urandom % 3) == 0);
      end
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, cur_sig, cur_cls, 1'b0, 1'b1);
      end
      checkOutput("queue_drained", 64'(sb_q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
